mul_hilo_wb: RTL and testbench
==============================

MUL_HILO_WB -- requirements
Module: mul_hilo_wb

Interface
REQ-001 SHALL use clock gated_clock and reset resetn (synchronous, active-low).
REQ-002 SHALL have these ports (name, direction, width, meaning):
- gated_clock  in  1  clock
- resetn  in  1  synchronous active-low reset
- fire  in  1  mul/shift op completes this cycle (issue start AND NOT mul-unit stalled)
- is_mul  in  1  fire is MULT/MULTU (1) or shift (0)
- dst  in  5  shift destination register
- hi_in, lo_in  in  32 each  mul-unit product halves, valid in fire cycle
- shift_in  in  32  mul-unit shift result, valid in fire cycle
- mfhi, mflo  in  1 each  move-from-HI/LO request
- mf_dst  in  5  MFHI/MFLO destination register
- mthi, mtlo  in  1 each  move-to-HI/LO request
- mt_data  in  32  MTHI/MTLO data
- wb_grant  in  1  register-file write port accepts head entry this cycle
- wb_valid  out  1  head entry present
- wb_dst  out  5  head destination
- wb_data  out  32  head data
- hi, lo  out  32 each  architectural HI/LO registers
- full_stall  out  1  upstream SHALL hold its request this cycle

Function
REQ-003 SHALL hold writebacks in a 2-entry in-order queue of {dst, data}; head drives wb_dst/wb_data; wb_valid = queue non-empty.
REQ-004 SHALL push shift_in with dst when fire & ~is_mul & dst!=0; dst==0 SHALL NOT push.
REQ-005 SHALL push hi (mfhi) or lo (mflo) register value with mf_dst when mf_dst!=0; mf_dst==0 SHALL NOT push.
REQ-006 SHALL pop head at the edge where wb_valid & wb_grant.
REQ-007 Push latency SHALL be one cycle: accepted at edge N -> wb_valid/wb_data visible in cycle N+1.
REQ-008 full_stall SHALL be combinational: count==2 & ~wb_grant; a push request while full_stall=1 SHALL be dropped (caller holds and retries).
REQ-009 Push and pop in the same cycle SHALL be accepted at count 1 or 2; count unchanged, order preserved.
REQ-010 Queue states EMPTY(0) -> ONE(1) -> FULL(2); transitions by push/pop only; no wrap past FULL or below EMPTY.
REQ-011 fire & is_mul SHALL load hi<=hi_in, lo<=lo_in at that edge, independent of queue state and full_stall.
REQ-012 mthi SHALL load hi<=mt_data; mtlo SHALL load lo<=mt_data; never stalled.
REQ-013 Upstream issues at most one of fire/mfhi/mflo/mthi/mtlo per cycle; if violated, priority SHALL be fire > mthi/mtlo > mfhi/mflo; lower-priority requests are ignored.
REQ-014 MFHI/MFLO SHALL read the registered hi/lo (value after all prior edges); no combinational bypass from hi_in/lo_in.
REQ-015 wb_dst/wb_data SHALL hold stable while wb_valid & ~wb_grant.

Reset
REQ-016 resetn=0 at an edge SHALL clear count to 0 and hi, lo, wb_dst, wb_data to 0; wb_valid=0 and full_stall=0 follow.
REQ-017 Reset mid-operation SHALL discard queued entries and all same-cycle requests.

Structure
REQ-018 Package mul_wb_pkg SHALL hold REG_W=32, DST_W=5, WB_DEPTH=2 and the queue-state enum (EMPTY, ONE, FULL).
REQ-019 Queue SHALL be a sub-module wb_fifo2 (push, pop, data in/out, count, full); HI/LO registers and push muxing stay at top level.

Verification
REQ-020 Shift fire dst=5, shift_in=0x0000_00F0, wb_grant=1 -> next cycle wb_valid=1, wb_dst=5, wb_data=0xF0; following cycle wb_valid=0.
REQ-021 Mul fire hi_in=0x1, lo_in=0xFFFF_FFFE, then mfhi mf_dst=3 -> hi=0x1; wb entry {3, 0x1} one cycle after mfhi.
REQ-022 wb_grant=0, three shift fires dst=1,2,3 -> count 2 after two; full_stall=1 on third (dropped); grant once -> dst=1 written back, retried dst=3 accepted, order 1,2,3.
REQ-023 Full queue, wb_grant=1, push same cycle -> full_stall=0, push accepted, count stays 2.
REQ-024 mthi mt_data=0xDEAD_BEEF, then fire & is_mul with dst=0 -> hi ends 0xDEAD_BEEF then hi_in; no push from either.
REQ-025 Queue FULL, hi=0x55, resetn=0 one cycle -> wb_valid=0, hi=0, lo=0, full_stall=0 next cycle.

Source files
------------

// File: rtl/mul_wb_pkg.sv
// Shared types and sizes for the HI/LO + writeback-queue block.
//   REG_W    : data width of HI/LO and writeback data
//   DST_W    : register-file destination index width
//   WB_DEPTH : writeback queue depth
//   q_state_t: queue occupancy state, encoded as the entry count
package mul_wb_pkg;
  localparam int REG_W    = 32;
  localparam int DST_W    = 5;
  localparam int WB_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } q_state_t;

  typedef struct packed {
    logic [DST_W-1:0] dst;
    logic [REG_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/mul_hilo_wb_if.sv
// Issue-side requests and writeback-port handshake for mul_hilo_wb.
//   slave  : the HI/LO block (consumes requests, drives writeback head)
//   master : upstream issue logic + register-file write port
interface mul_hilo_wb_if;
  import mul_wb_pkg::*;
  logic             fire;
  logic             is_mul;
  logic [DST_W-1:0] dst;
  logic [REG_W-1:0] hi_in;
  logic [REG_W-1:0] lo_in;
  logic [REG_W-1:0] shift_in;
  logic             mfhi;
  logic             mflo;
  logic [DST_W-1:0] mf_dst;
  logic             mthi;
  logic             mtlo;
  logic [REG_W-1:0] mt_data;
  logic             wb_grant;
  logic             wb_valid;
  logic [DST_W-1:0] wb_dst;
  logic [REG_W-1:0] wb_data;
  logic             full_stall;

  modport slave (
    input  fire, is_mul, dst, hi_in, lo_in, shift_in,
           mfhi, mflo, mf_dst, mthi, mtlo, mt_data, wb_grant,
    output wb_valid, wb_dst, wb_data, full_stall
  );
  modport master (
    output fire, is_mul, dst, hi_in, lo_in, shift_in,
           mfhi, mflo, mf_dst, mthi, mtlo, mt_data, wb_grant,
    input  wb_valid, wb_dst, wb_data, full_stall
  );
endinterface

// File: rtl/wb_fifo2.sv
// Two-entry in-order writeback queue. Slot 0 is always the head, so the
// output is a plain register and stays stable until popped.
//   gated_clock, resetn : clock, synchronous active-low reset
//   push_i / din_i      : enqueue request and entry (ignored when full w/o pop)
//   pop_i               : dequeue head (ignored when empty)
//   dout_o              : head entry
//   count_o             : occupancy 0..2
//   full_o              : occupancy == 2
module wb_fifo2
  import mul_wb_pkg::*;
(
  input  logic       gated_clock,
  input  logic       resetn,
  input  logic       push_i,
  input  logic       pop_i,
  input  wb_entry_t  din_i,
  output wb_entry_t  dout_o,
  output logic [1:0] count_o,
  output logic       full_o
);
  q_state_t  state_q, state_d;
  wb_entry_t mem_q [WB_DEPTH];
  wb_entry_t mem_d [WB_DEPTH];
  logic      do_push, do_pop;

  assign do_pop  = pop_i & (state_q != EMPTY);
  assign do_push = push_i & ((state_q != FULL) | do_pop);

  always_ff @(posedge gated_clock) begin
    if (!resetn) begin
      state_q  <= EMPTY;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    unique case (state_q)
      EMPTY: if (do_push) begin
        mem_d[0] = din_i;
        state_d  = ONE;
      end
      ONE: begin
        if (do_push && do_pop) begin
          mem_d[0] = din_i;
        end else if (do_push) begin
          mem_d[1] = din_i;
          state_d  = FULL;
        end else if (do_pop) begin
          state_d  = EMPTY;
        end
      end
      FULL: if (do_pop) begin
        // Shift tail into head; a same-cycle push refills the tail.
        mem_d[0] = mem_q[1];
        if (do_push) mem_d[1] = din_i;
        else         state_d  = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  assign dout_o  = mem_q[0];
  assign count_o = state_q;
  assign full_o  = (state_q == FULL);
endmodule

// File: rtl/mul_hilo_wb.sv
// Architectural HI/LO registers plus the writeback queue for shift results
// and MFHI/MFLO. Mul completions load HI/LO directly; shifts and moves-from
// go through a 2-entry queue to the register-file write port.
//   gated_clock, resetn : clock, synchronous active-low reset
//   bus (slave)         : issue requests, writeback head, full_stall
//   hi, lo              : architectural HI/LO
module mul_hilo_wb
  import mul_wb_pkg::*;
(
  input  logic             gated_clock,
  input  logic             resetn,
  mul_hilo_wb_if.slave     bus,
  output logic [REG_W-1:0] hi,
  output logic [REG_W-1:0] lo
);
  logic [REG_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             push_req, push, pop, full;
  wb_entry_t        push_ent, head;
  logic [1:0]       count;

  always_ff @(posedge gated_clock) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Priority fire > mthi/mtlo > mfhi/mflo. Moves-from read the registered
  // HI/LO only, so a same-cycle mul result is never forwarded.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    push_req = 1'b0;
    push_ent = '0;
    if (bus.fire) begin
      if (bus.is_mul) begin
        hi_d = bus.hi_in;
        lo_d = bus.lo_in;
      end else if (bus.dst != '0) begin
        push_req = 1'b1;
        push_ent = '{dst: bus.dst, data: bus.shift_in};
      end
    end else if (bus.mthi || bus.mtlo) begin
      if (bus.mthi) hi_d = bus.mt_data;
      if (bus.mtlo) lo_d = bus.mt_data;
    end else if ((bus.mfhi || bus.mflo) && bus.mf_dst != '0) begin
      push_req = 1'b1;
      push_ent = '{dst: bus.mf_dst, data: (bus.mfhi ? hi_q : lo_q)};
    end
  end

  // A grant frees the head slot this cycle, so a full queue can still
  // accept; only full-without-grant stalls.
  assign bus.full_stall = full & ~bus.wb_grant;
  assign push           = push_req & ~bus.full_stall;
  assign pop            = bus.wb_valid & bus.wb_grant;

  wb_fifo2 u_fifo (
    .gated_clock (gated_clock),
    .resetn      (resetn),
    .push_i      (push),
    .pop_i       (pop),
    .din_i       (push_ent),
    .dout_o      (head),
    .count_o     (count),
    .full_o      (full)
  );

  assign bus.wb_valid = (count != 2'd0);
  assign bus.wb_dst   = head.dst;
  assign bus.wb_data  = head.data;
  assign hi           = hi_q;
  assign lo           = lo_q;
endmodule

// File: tb/tb_mul_hilo_wb.sv
module tb_mul_hilo_wb;
  import mul_wb_pkg::*;

  logic             gated_clock = 1'b0;
  logic             resetn;
  logic [REG_W-1:0] hi, lo;
  int               nvec = 0;
  int               nerr = 0;
  wb_entry_t        exp_q [$];

  mul_hilo_wb_if bus ();

  mul_hilo_wb dut (
    .gated_clock (gated_clock),
    .resetn      (resetn),
    .bus         (bus.slave),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 gated_clock = ~gated_clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.fire = 0; bus.is_mul = 0; bus.dst = 0; bus.hi_in = 0; bus.lo_in = 0;
    bus.shift_in = 0; bus.mfhi = 0; bus.mflo = 0; bus.mf_dst = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.mt_data = 0;
  endtask

  task automatic step();
    @(posedge gated_clock);
    #1;
  endtask

  task automatic shift(input logic [4:0] d, input logic [31:0] v);
    idle();
    bus.fire = 1; bus.dst = d; bus.shift_in = v;
  endtask

  task automatic mul(input logic [31:0] h, input logic [31:0] l);
    idle();
    bus.fire = 1; bus.is_mul = 1; bus.hi_in = h; bus.lo_in = l;
  endtask

  // Monitor: each granted head is a write into the register file; compare
  // it against the oldest expected entry.
  always @(negedge gated_clock) begin
    if (resetn === 1'b1 && bus.wb_valid === 1'b1 && bus.wb_grant === 1'b1) begin
      if (exp_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL wb_unexpected: got dst=%0d data=%h expected none", bus.wb_dst, bus.wb_data);
      end else begin
        wb_entry_t e;
        e = exp_q.pop_front();
        chk("wb_dst", 32'(bus.wb_dst), 32'(e.dst));
        chk("wb_data", bus.wb_data, e.data);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    nerr++;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1);
  end

  initial begin
    idle();
    bus.wb_grant = 0;
    resetn = 0;
    step(); step();
    resetn = 1;
    chk("rst_wb_valid", 32'(bus.wb_valid), 0);
    chk("rst_full_stall", 32'(bus.full_stall), 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_wb_data", bus.wb_data, 0);

    // Single shift writeback, granted immediately.
    bus.wb_grant = 1;
    shift(5, 32'h0000_00F0); exp_q.push_back('{5, 32'hF0});
    step(); idle();
    chk("sh_valid", 32'(bus.wb_valid), 1);
    chk("sh_dst", 32'(bus.wb_dst), 5);
    chk("sh_data", bus.wb_data, 32'hF0);
    step();
    chk("sh_drained", 32'(bus.wb_valid), 0);

    // Mul then MFHI / MFLO.
    mul(32'h1, 32'hFFFF_FFFE);
    step(); idle();
    chk("mul_hi", hi, 32'h1);
    chk("mul_lo", lo, 32'hFFFF_FFFE);
    bus.mfhi = 1; bus.mf_dst = 3; exp_q.push_back('{3, 32'h1});
    step(); idle();
    chk("mfhi_valid", 32'(bus.wb_valid), 1);
    chk("mfhi_data", bus.wb_data, 32'h1);
    bus.mflo = 1; bus.mf_dst = 4; exp_q.push_back('{4, 32'hFFFF_FFFE});
    step(); idle();
    step();
    // dst==0 pushes nothing.
    bus.mfhi = 1; bus.mf_dst = 0;
    step(); idle();
    chk("mf_dst0", 32'(bus.wb_valid), 0);
    shift(0, 32'h1234);
    step(); idle();
    chk("sh_dst0", 32'(bus.wb_valid), 0);

    // Fill with grant low, third push stalls and is retried.
    bus.wb_grant = 0;
    shift(1, 32'h11); exp_q.push_back('{1, 32'h11});
    step();
    shift(2, 32'h22); exp_q.push_back('{2, 32'h22});
    step();
    shift(3, 32'h33);
    #1 chk("stall_full", 32'(bus.full_stall), 1);
    step();
    chk("stall_head", 32'(bus.wb_dst), 1);
    bus.wb_grant = 1;
    #1 chk("stall_release", 32'(bus.full_stall), 0);
    exp_q.push_back('{3, 32'h33});
    step(); idle(); bus.wb_grant = 0;
    #1 chk("stall_still_full", 32'(bus.full_stall), 1);
    bus.wb_grant = 1;
    step(); step();
    chk("stall_drained", 32'(bus.wb_valid), 0);

    // Full queue, grant and push in the same cycle.
    bus.wb_grant = 0;
    shift(6, 32'h66); exp_q.push_back('{6, 32'h66});
    step();
    shift(7, 32'h77); exp_q.push_back('{7, 32'h77});
    step();
    shift(8, 32'h88); bus.wb_grant = 1;
    #1 chk("pp_no_stall", 32'(bus.full_stall), 0);
    exp_q.push_back('{8, 32'h88});
    step(); idle(); bus.wb_grant = 0;
    #1 chk("pp_count2", 32'(bus.full_stall), 1);
    chk("pp_head", 32'(bus.wb_dst), 7);
    bus.wb_grant = 1;
    step(); step();
    chk("pp_drained", 32'(bus.wb_valid), 0);

    // Move-to, then mul with dst=0 overrides HI and pushes nothing.
    idle(); bus.mthi = 1; bus.mt_data = 32'hDEAD_BEEF;
    step(); idle();
    chk("mthi", hi, 32'hDEAD_BEEF);
    bus.mtlo = 1; bus.mt_data = 32'h1234_5678;
    step(); idle();
    chk("mtlo", lo, 32'h1234_5678);
    chk("mtlo_hi_kept", hi, 32'hDEAD_BEEF);
    mul(32'hA5A5_0001, 32'h5A5A_0002);
    step(); idle();
    chk("mul2_hi", hi, 32'hA5A5_0001);
    chk("mul2_lo", lo, 32'h5A5A_0002);
    chk("mul2_nopush", 32'(bus.wb_valid), 0);

    // Priority: fire beats mthi; mthi beats mfhi.
    mul(32'h0000_0C0C, 32'h0000_0D0D); bus.mthi = 1; bus.mt_data = 32'hFFFF_0000;
    step(); idle();
    chk("prio_fire_hi", hi, 32'h0000_0C0C);
    bus.mthi = 1; bus.mt_data = 32'h0000_0099; bus.mfhi = 1; bus.mf_dst = 9;
    step(); idle();
    chk("prio_mt_hi", hi, 32'h99);
    chk("prio_mt_nopush", 32'(bus.wb_valid), 0);

    // Reset with a full queue and a same-cycle request.
    bus.wb_grant = 0;
    bus.mthi = 1; bus.mt_data = 32'h55;
    step();
    shift(10, 32'hAA);
    step();
    shift(11, 32'hBB);
    step();
    chk("pre_rst_full", 32'(bus.full_stall), 1);
    chk("pre_rst_hi", hi, 32'h55);
    shift(12, 32'hCC);
    resetn = 0;
    step();
    resetn = 1; idle();
    chk("rst2_valid", 32'(bus.wb_valid), 0);
    chk("rst2_hi", hi, 0);
    chk("rst2_lo", lo, 0);
    chk("rst2_stall", 32'(bus.full_stall), 0);
    step();
    chk("rst2_no_late_push", 32'(bus.wb_valid), 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
